stdp_stim_scheduler: RTL
========================

# stdp_stim_scheduler

Epoch-based stimulus and learning controller for the two-neuron LIF/STDP core. Each epoch drives the core's input current through three phases (STRONG, WEAK, REST) and gates STDP learning on during the driven phases. It counts N1/N2 spikes and synaptic-weight changes over a run, then reports completion with a start/busy/done handshake. It sits between the top-level control pins and the neuron core's current input and learning-enable input.

## Interface
- `CUR_W`, 8, current-level width (matches core input)
- `LEN_W`, 8, phase-length counter width
- `EPOCH_W`, 4, epoch count width
- `CNT_W`, 8, statistics counter width
- `WGT_W`, 6, synaptic weight width
- `clk` in 1, single clock domain
- `rst` in 1, asynchronous active-high reset
- `start` in 1, run request, sampled only in IDLE
- `abort` in 1, synchronous return to IDLE, priority over `start`
- `cfg_strong`, `cfg_weak` in CUR_W, current levels for STRONG and WEAK
- `cfg_len_strong`, `cfg_len_weak`, `cfg_len_rest` in LEN_W, phase lengths in cycles
- `cfg_epochs` in EPOCH_W, number of epochs
- `cfg_learn` in 1, enables STDP during driven phases
- `spike_n1`, `spike_n2` in 1, one-cycle spike flags from the core
- `weight` in WGT_W, current synaptic weight from the core
- `current` out CUR_W, registered drive to the core
- `stdp_en` out 1, registered learning enable
- `phase` out 2, IDLE=0, STRONG=1, WEAK=2, REST=3
- `busy` out 1, high in any non-IDLE phase
- `done` out 1, one-cycle pulse at normal completion
- `epoch` out EPOCH_W, completed-epoch count
- `n1_count`, `n2_count`, `wchg_count` out CNT_W, saturating statistics

## Operation
- Reset: phase=IDLE, `current`=0, `stdp_en`=0, `busy`=0, `done`=0, `epoch`=0, all counters 0, latched config 0, weight shadow 0.
- Start is accepted when `start`=1 in IDLE and `abort`=0.
  - Latch all `cfg_*` values. Later cfg changes have no effect until the next start.
  - Clear `epoch`, `n1_count`, `n2_count` and `wchg_count`. Load the weight shadow from `weight`. Enter STRONG.
- `start` while busy is ignored.
- A length or `cfg_epochs` value of 0 is treated as 1.
- FSM transitions:
  - IDLE -> STRONG on accepted start.
  - STRONG -> WEAK after Ls cycles.
  - WEAK -> REST after Lw cycles.
  - At the end of Lr cycles of REST, `epoch` increments. If the new count equals E, go to IDLE and pulse `done`. Otherwise go to STRONG.
- Output levels by phase:
  - `current` = latched strong in STRONG, latched weak in WEAK, 0 in REST and IDLE.
  - `stdp_en` = latched learn AND phase in {STRONG, WEAK}.
- Counting rules:
  - While busy, each `spike_n1` / `spike_n2` increments its counter.
  - While busy, `weight` != shadow increments `wchg_count` and updates the shadow.
  - All counters saturate at 2^CNT_W-1.
  - Spikes in the start-accept cycle are not counted; spikes in the final REST cycle are counted.
- Abort, from any state: next edge goes to IDLE with `current`=0 and `stdp_en`=0, and no `done` pulse. Counters and `epoch` hold their values for readout.
- Reset mid-run: immediate return to reset values, with no `done` pulse.

## Timing
- Start sampled at edge t: `phase`=STRONG, `busy`=1 and `current`=strong are visible after edge t. Latency is one cycle.
- Each phase output is held for exactly its length in cycles. A run is busy for E*(Ls+Lw+Lr) cycles.
- `done` is high for the single cycle after the final REST cycle, coincident with `busy`=0 and `epoch`=E.
- A new `start` is accepted in the same cycle `done` is high.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `lif_sched_pkg` holds:
  - the phase enum (IDLE/STRONG/WEAK/REST) with its 2-bit encoding;
  - default widths CUR_W/LEN_W/EPOCH_W/CNT_W/WGT_W.
- Sub-module `sat_counter` (parameter width; inputs clr and inc; output count saturating at all-ones). It is instantiated 3x, for `n1_count`, `n2_count` and `wchg_count`.
- Top contains the FSM, the phase-length down-counter, the epoch counter, the config latches and the weight shadow.

## Test plan
- Nominal run: strong=0xFF, weak=0x80, lengths 10/10/10, epochs=10, learn=1.
  - `current` sequence is 0xFF×10, 0x80×10, 0x00×10, repeated.
  - `stdp_en` is high for 20 of every 30 cycles; `busy` lasts 300 cycles; `done` pulses once; `epoch`=10.
- Zero handling: all lengths 0, epochs 0.
  - Expect STRONG/WEAK/REST for 1 cycle each, then `done` after 3 busy cycles with `epoch`=1.
- Statistics: inject 300 `spike_n1` pulses and 5 `spike_n2` pulses during a long run; change `weight` 3 times, holding each new value several cycles.
  - `n1_count`=255 (saturated), `n2_count`=5, `wchg_count`=3. A spike coincident with the start-accept cycle is not counted.
- Abort mid-WEAK in epoch 2 → next cycle `phase`=IDLE, `current`=0, `stdp_en`=0, no `done`; `epoch`=2 and counters hold.
- Start while busy and cfg changes mid-run are ignored. Start on the `done` cycle is accepted and counters clear.
- Assert `rst` mid-STRONG → outputs go to reset values immediately (asynchronously); after release, the block idles until `start`.

Source files
------------

// File: rtl/lif_sched_pkg.sv
// Shared types and default widths for the LIF/STDP stimulus scheduler.
package lif_sched_pkg;

  localparam int CUR_W   = 8;
  localparam int LEN_W   = 8;
  localparam int EPOCH_W = 4;
  localparam int CNT_W   = 8;
  localparam int WGT_W   = 6;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_STRONG = 2'd1,
    PH_WEAK   = 2'd2,
    PH_REST   = 2'd3
  } phase_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that clears on request and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear wins over increment; increment stops at the all-ones value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != {WIDTH{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/stdp_stim_scheduler.sv
// Epoch-based STRONG/WEAK/REST drive sequencer with STDP gating and run statistics.
//
// state     | meaning
// ----------+------------------------------------------------------------
// PH_IDLE   | waiting for start; current=0, learning off
// PH_STRONG | driving latched strong level; learning gated by latched learn
// PH_WEAK   | driving latched weak level; learning gated by latched learn
// PH_REST   | no drive; epoch count advances at the end of this phase
module stdp_stim_scheduler #(
  parameter int CUR_W   = lif_sched_pkg::CUR_W,
  parameter int LEN_W   = lif_sched_pkg::LEN_W,
  parameter int EPOCH_W = lif_sched_pkg::EPOCH_W,
  parameter int CNT_W   = lif_sched_pkg::CNT_W,
  parameter int WGT_W   = lif_sched_pkg::WGT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CUR_W-1:0]   cfg_strong,
  input  logic [CUR_W-1:0]   cfg_weak,
  input  logic [LEN_W-1:0]   cfg_len_strong,
  input  logic [LEN_W-1:0]   cfg_len_weak,
  input  logic [LEN_W-1:0]   cfg_len_rest,
  input  logic [EPOCH_W-1:0] cfg_epochs,
  input  logic               cfg_learn,
  input  logic               spike_n1,
  input  logic               spike_n2,
  input  logic [WGT_W-1:0]   weight,
  output logic [CUR_W-1:0]   current,
  output logic               stdp_en,
  output logic [1:0]         phase,
  output logic               busy,
  output logic               done,
  output logic [EPOCH_W-1:0] epoch,
  output logic [CNT_W-1:0]   n1_count,
  output logic [CNT_W-1:0]   n2_count,
  output logic [CNT_W-1:0]   wchg_count
);
  import lif_sched_pkg::*;

  phase_t             ph_q, ph_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d, epochs_eff;
  logic [CUR_W-1:0]   strong_q, weak_q, cur_d;
  logic [LEN_W-1:0]   ls_q, lw_q, lr_q;
  logic [EPOCH_W-1:0] ep_cfg_q;
  logic               learn_q, learn_d, stdp_d, done_d, accept;
  logic [WGT_W-1:0]   shadow_q;
  logic               busy_i, wchg;

  // Down-counter preload: a phase of length L (0 read as 1) ends when the count hits 0.
  function automatic logic [LEN_W-1:0] len_load(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  assign busy_i     = (ph_q != PH_IDLE);
  assign wchg       = busy_i && (weight != shadow_q);
  assign epochs_eff = (ep_cfg_q == '0) ? EPOCH_W'(1) : ep_cfg_q;

  assign phase = ph_q;
  assign busy  = busy_i;
  assign epoch = epoch_q;

  // Next phase, phase timer, epoch count and the registered output values.
  always_comb begin
    ph_d    = ph_q;
    len_d   = len_q;
    epoch_d = epoch_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    if (abort) begin
      ph_d = PH_IDLE;
    end else begin
      case (ph_q)
        PH_IDLE: begin
          if (start) begin
            accept  = 1'b1;
            ph_d    = PH_STRONG;
            len_d   = len_load(cfg_len_strong);
            epoch_d = '0;
          end
        end
        PH_STRONG: begin
          if (len_q == '0) begin
            ph_d  = PH_WEAK;
            len_d = len_load(lw_q);
          end else begin
            len_d = len_q - 1'b1;
          end
        end
        PH_WEAK: begin
          if (len_q == '0) begin
            ph_d  = PH_REST;
            len_d = len_load(lr_q);
          end else begin
            len_d = len_q - 1'b1;
          end
        end
        default: begin
          if (len_q == '0) begin
            epoch_d = epoch_q + 1'b1;
            if (epoch_d == epochs_eff) begin
              ph_d   = PH_IDLE;
              done_d = 1'b1;
            end else begin
              ph_d  = PH_STRONG;
              len_d = len_load(ls_q);
            end
          end else begin
            len_d = len_q - 1'b1;
          end
        end
      endcase
    end

    // On the accept cycle the latches are not loaded yet, so use the live config.
    learn_d = accept ? cfg_learn : learn_q;
    case (ph_d)
      PH_STRONG: cur_d = accept ? cfg_strong : strong_q;
      PH_WEAK:   cur_d = weak_q;
      default:   cur_d = '0;
    endcase
    stdp_d = learn_d && ((ph_d == PH_STRONG) || (ph_d == PH_WEAK));
  end

  // State, timer, epoch and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q    <= PH_IDLE;
      len_q   <= '0;
      epoch_q <= '0;
      current <= '0;
      stdp_en <= 1'b0;
      done    <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      len_q   <= len_d;
      epoch_q <= epoch_d;
      current <= cur_d;
      stdp_en <= stdp_d;
      done    <= done_d;
    end
  end

  // Config latches and weight shadow; config is frozen for the whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strong_q <= '0;
      weak_q   <= '0;
      ls_q     <= '0;
      lw_q     <= '0;
      lr_q     <= '0;
      ep_cfg_q <= '0;
      learn_q  <= 1'b0;
      shadow_q <= '0;
    end else if (accept) begin
      strong_q <= cfg_strong;
      weak_q   <= cfg_weak;
      ls_q     <= cfg_len_strong;
      lw_q     <= cfg_len_weak;
      lr_q     <= cfg_len_rest;
      ep_cfg_q <= cfg_epochs;
      learn_q  <= cfg_learn;
      shadow_q <= weight;
    end else if (wchg) begin
      shadow_q <= weight;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_n1_cnt (
    .clk(clk), .rst(rst), .clr(accept), .inc(busy_i && spike_n1), .count(n1_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_n2_cnt (
    .clk(clk), .rst(rst), .clr(accept), .inc(busy_i && spike_n2), .count(n2_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_wchg_cnt (
    .clk(clk), .rst(rst), .clr(accept), .inc(wchg), .count(wchg_count)
  );

endmodule
